// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the rest of the clock/reset fabric.
// The master drives lock, button and software request; the slave returns the domain resets and status.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3
);
  // No valid/ready pairing here: sw_rst_req_i is a one-cycle pulse that is acted on
  // only while ready_o is high; lock and button are level signals resynchronized inside.
  logic                   pll_locked_i;
  logic                   ext_rst_ni;
  logic                   sw_rst_req_i;
  logic [NUM_DOMAINS-1:0] rst_domain_o;
  logic                   ready_o;
  logic [3:0]             rst_cause_o;

  modport master (
    output pll_locked_i, ext_rst_ni, sw_rst_req_i,
    input  rst_domain_o, ready_o, rst_cause_o
  );

  modport slave (
    input  pll_locked_i, ext_rst_ni, sw_rst_req_i,
    output rst_domain_o, ready_o, rst_cause_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes PLL lock, debounces the reset button, stretches reset
// after lock and releases the downstream domains in a staggered order, recording the cause.
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STRETCH_CYCLES  = 16,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic               clk_sys,
  input  logic               rst_sys,
  reset_sequencer_if.slave   bus,
  output logic [2:0]         state_dbg
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
  localparam int SG_W = $clog2(STAGGER_CYCLES + 1);
  localparam logic [NUM_DOMAINS-1:0] ALL_ONES  = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] LAST_MASK = NUM_DOMAINS'(1) << (NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STRETCH   = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_ASSERT    = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   btn_db;
  logic [DB_W-1:0]        db_cnt;
  logic [ST_W-1:0]        st_cnt;
  logic [SG_W-1:0]        sg_cnt;
  logic [NUM_DOMAINS-1:0] rst_domain;
  logic                   ready;
  logic [3:0]             rst_cause;

  logic lock_s;
  logic btn_s;
  logic press;

  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign btn_s     = btn_sync[SYNC_STAGES-1];
  assign press     = ~btn_db;
  assign state_dbg = state;

  assign bus.rst_domain_o = rst_domain;
  assign bus.ready_o      = ready;
  assign bus.rst_cause_o  = rst_cause;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], bus.ext_rst_ni};
    end
  end

  // The debounced level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state      <= S_RESET;
      st_cnt     <= '0;
      sg_cnt     <= '0;
      rst_domain <= ALL_ONES;
      ready      <= 1'b0;
      rst_cause  <= 4'b0001;
    end else begin
      case (state)
        S_RESET: state <= S_WAIT_LOCK;

        S_WAIT_LOCK: begin
          st_cnt <= '0;
          if (lock_s && !press) state <= S_STRETCH;
        end

        S_STRETCH: begin
          if (!lock_s || press) begin
            state  <= S_WAIT_LOCK;
            st_cnt <= '0;
          end else if (st_cnt == ST_W'(STRETCH_CYCLES - 1)) begin
            st_cnt     <= '0;
            sg_cnt     <= '0;
            rst_domain <= ALL_ONES << 1;
            if (NUM_DOMAINS == 1) begin
              state <= S_RUN;
              ready <= 1'b1;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end

        // Domains drop one at a time from bit 0 upward; the shift keeps the order fixed.
        S_RELEASE: begin
          if (!lock_s || press) begin
            state      <= S_ASSERT;
            sg_cnt     <= '0;
            rst_domain <= ALL_ONES;
            ready      <= 1'b0;
            rst_cause  <= {1'b0, press, !lock_s, 1'b0};
          end else if (sg_cnt == SG_W'(STAGGER_CYCLES - 1)) begin
            sg_cnt     <= '0;
            rst_domain <= rst_domain << 1;
            if (rst_domain == LAST_MASK) begin
              state <= S_RUN;
              ready <= 1'b1;
            end
          end else begin
            sg_cnt <= sg_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!lock_s || press || bus.sw_rst_req_i) begin
            state      <= S_ASSERT;
            rst_domain <= ALL_ONES;
            ready      <= 1'b0;
            rst_cause  <= {bus.sw_rst_req_i, press, !lock_s, 1'b0};
          end
        end

        S_ASSERT: state <= S_WAIT_LOCK;

        default: begin
          state      <= S_RESET;
          rst_domain <= ALL_ONES;
          ready      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a POR vector table plus hand-written sequences for
// software, lock-loss, button and mid-release reset corners.
module tb_reset_sequencer;
  logic       clk;
  logic       rst_sys;
  logic [2:0] state_main;
  logic [2:0] state_small;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  logic [3:0] exp_q[$];

  reset_sequencer_if #(.NUM_DOMAINS(3)) if_main ();
  reset_sequencer_if #(.NUM_DOMAINS(1)) if_small ();

  reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(16),
    .NUM_DOMAINS(3), .STAGGER_CYCLES(8)
  ) u_main (
    .clk_sys(clk), .rst_sys(rst_sys), .bus(if_main.slave), .state_dbg(state_main)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(1),
    .NUM_DOMAINS(1), .STAGGER_CYCLES(8)
  ) u_small (
    .clk_sys(clk), .rst_sys(rst_sys), .bus(if_small.slave), .state_dbg(state_small)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [2:0] dom;
    logic       rdy;
    logic [2:0] st;
    logic       sdom;
    logic       srdy;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic check_main(input string name, input logic [2:0] dom, input logic rdy,
                            input logic [2:0] st);
    check({name, "_dom"}, 32'(if_main.rst_domain_o), 32'(dom));
    check({name, "_rdy"}, 32'(if_main.ready_o), 32'(rdy));
    check({name, "_st"}, 32'(state_main), 32'(st));
  endtask

  task automatic check_cause(input string name);
    logic [3:0] exp;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_cause"}, 32'(if_main.rst_cause_o), 32'(exp));
    end
  endtask

  // From the edge that entered STRETCH: full stretch count then the three staggered drops.
  task automatic finish_release(input string name);
    repeat (15) tick();
    check_main({name, "_stretch_end"}, 3'b111, 1'b0, 3'd2);
    tick();
    check_main({name, "_bit0"}, 3'b110, 1'b0, 3'd3);
    repeat (7) tick();
    check_main({name, "_bit1_pre"}, 3'b110, 1'b0, 3'd3);
    tick();
    check_main({name, "_bit1"}, 3'b100, 1'b0, 3'd3);
    repeat (7) tick();
    check_main({name, "_bit2_pre"}, 3'b100, 1'b0, 3'd3);
    tick();
    check_main({name, "_bit2"}, 3'b000, 1'b1, 3'd4);
  endtask

  task automatic sw_pulse(input string name);
    if_main.sw_rst_req_i = 1'b1;
    tick();
    if_main.sw_rst_req_i = 1'b0;
    check_main({name, "_assert"}, 3'b111, 1'b0, 3'd5);
    check_cause(name);
  endtask

  initial begin
    int hit;
    vecs[0] = '{1,  3'b111, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[1] = '{2,  3'b111, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[2] = '{3,  3'b111, 1'b0, 3'd2, 1'b1, 1'b0};
    vecs[3] = '{4,  3'b111, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[4] = '{18, 3'b111, 1'b0, 3'd2, 1'b0, 1'b1};
    vecs[5] = '{19, 3'b110, 1'b0, 3'd3, 1'b0, 1'b1};
    vecs[6] = '{26, 3'b110, 1'b0, 3'd3, 1'b0, 1'b1};
    vecs[7] = '{27, 3'b100, 1'b0, 3'd3, 1'b0, 1'b1};
    vecs[8] = '{34, 3'b100, 1'b0, 3'd3, 1'b0, 1'b1};
    vecs[9] = '{35, 3'b000, 1'b1, 3'd4, 1'b0, 1'b1};

    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0001);

    rst_sys = 1'b1;
    if_main.pll_locked_i  = 1'b1;
    if_main.ext_rst_ni    = 1'b1;
    if_main.sw_rst_req_i  = 1'b0;
    if_small.pll_locked_i = 1'b1;
    if_small.ext_rst_ni   = 1'b1;
    if_small.sw_rst_req_i = 1'b0;
    repeat (3) tick();
    check_main("por_hold", 3'b111, 1'b0, 3'd0);
    check("por_hold_cause", 32'(if_main.rst_cause_o), 32'h1);
    check("por_hold_small_dom", 32'(if_small.rst_domain_o), 32'h1);

    rst_sys = 1'b0;
    edge_n = 0;
    foreach (vecs[i]) begin
      while (edge_n < vecs[i].e) tick();
      check_main($sformatf("por_e%0d", vecs[i].e), vecs[i].dom, vecs[i].rdy, vecs[i].st);
      check($sformatf("small_e%0d_dom", vecs[i].e), 32'(if_small.rst_domain_o), 32'(vecs[i].sdom));
      check($sformatf("small_e%0d_rdy", vecs[i].e), 32'(if_small.ready_o), 32'(vecs[i].srdy));
    end
    check("por_cause", 32'(if_main.rst_cause_o), 32'h1);

    // software request and full replay
    repeat (3) tick();
    sw_pulse("sw1");
    tick();
    check("sw1_wait_st", 32'(state_main), 32'd1);
    tick();
    check("sw1_stretch_st", 32'(state_main), 32'd2);
    finish_release("sw1");

    // lock dropped for 5 cycles mid-stretch; stretch restarts from zero
    sw_pulse("sw2");
    tick();
    tick();
    repeat (5) tick();
    if_main.pll_locked_i = 1'b0;
    repeat (5) tick();
    check_main("lockdrop_wait", 3'b111, 1'b0, 3'd1);
    if_main.pll_locked_i = 1'b1;
    tick();
    tick();
    check("relock_wait_st", 32'(state_main), 32'd1);
    tick();
    check("relock_stretch_st", 32'(state_main), 32'd2);
    finish_release("relock");
    check("relock_cause_held", 32'(if_main.rst_cause_o), 32'h8);

    // short glitch must be filtered
    if_main.ext_rst_ni = 1'b0;
    repeat (3) tick();
    if_main.ext_rst_ni = 1'b1;
    repeat (12) begin
      tick();
      check("glitch_ready", 32'(if_main.ready_o), 32'h1);
    end

    // held press: ASSERT SYNC_STAGES+DEBOUNCE_CYCLES+1 edges later
    if_main.ext_rst_ni = 1'b0;
    hit = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (state_main == 3'd5 && hit == 0) begin
        hit = k;
        check_main("press_assert", 3'b111, 1'b0, 3'd5);
        check_cause("press");
      end
    end
    check("press_latency", 32'(hit), 32'd7);
    if_main.ext_rst_ni = 1'b1;
    repeat (6) tick();
    check_main("press_held_wait", 3'b111, 1'b0, 3'd1);
    tick();
    check("press_stretch_st", 32'(state_main), 32'd2);
    finish_release("press");

    // lock loss and software request on the same ASSERT edge
    if_main.pll_locked_i = 1'b0;
    tick();
    tick();
    sw_pulse("lock_sw");
    if_main.pll_locked_i = 1'b1;
    tick();
    tick();
    check("lock_sw_wait_st", 32'(state_main), 32'd1);
    tick();
    check("lock_sw_stretch_st", 32'(state_main), 32'd2);
    repeat (16) tick();
    check_main("midrel_bit0", 3'b110, 1'b0, 3'd3);
    repeat (3) tick();

    // synchronous reset during RELEASE
    rst_sys = 1'b1;
    tick();
    check_main("midrel_rst", 3'b111, 1'b0, 3'd0);
    check_cause("midrel_rst");
    check("midrel_small_dom", 32'(if_small.rst_domain_o), 32'h1);
    check("midrel_small_rdy", 32'(if_small.ready_o), 32'h0);
    rst_sys = 1'b0;
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
